// File: rtl/systolic_pkg.sv
// Shared types for the systolic array result drain.
// Holds the drain controller state encoding.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      FLUSH
   } drain_state_t;

endpackage

// File: rtl/systolic_result_drain.sv
// Drains a size x size systolic result array row-major into a
// valid/ready result stream through a one-entry output register.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   go_val / go_rdy     drain request handshake (ready only in IDLE)
//   out_rsel/out_csel   row/column select to the array (registered index)
//   b_s_out             array word at the current selects (combinational)
//   send_val/send_rdy   result stream handshake
//   send_msg            result word
//   done                one-cycle pulse when the final word is accepted
//   send_last           (only with SYSTOLIC_DRAIN_LAST_EN) marks the
//                       final word (size-1,size-1)
module systolic_result_drain
   import systolic_pkg::*;
#(
   parameter int size  = 16,
   parameter int nbits = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    go_val,
   output logic                    go_rdy,
   output logic [$clog2(size)-1:0] out_rsel,
   output logic [$clog2(size)-1:0] out_csel,
   input  logic [nbits-1:0]        b_s_out,
   output logic                    send_val,
   input  logic                    send_rdy,
   output logic [nbits-1:0]        send_msg,
`ifdef SYSTOLIC_DRAIN_LAST_EN
   output logic                    send_last,
`endif
   output logic                    done
);

   localparam int IW = $clog2(size);
   localparam logic [IW-1:0] LAST = IW'(size - 1);
   localparam logic [IW-1:0] ONE  = IW'(1);

   drain_state_t   state_q, state_d;
   logic [IW-1:0]  row_q, row_d;
   logic [IW-1:0]  col_q, col_d;
   logic           full_q, full_d;
   logic [nbits-1:0] msg_q, msg_d;
   logic           accept;

   assign accept = full_q && send_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         full_q  <= 1'b0;
         msg_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         full_q  <= full_d;
         msg_q   <= msg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      full_d  = full_q;
      msg_d   = msg_q;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (go_val) begin
               state_d = DRAIN;
               row_d   = '0;
               col_d   = '0;
            end
         end
         DRAIN: begin
            // Load whenever the register is empty or draining this
            // cycle; otherwise the index stalls with the register.
            if (!full_q || send_rdy) begin
               full_d = 1'b1;
               msg_d  = b_s_out;
               if (row_q == LAST && col_q == LAST) begin
                  state_d = FLUSH;
               end else if (col_q == LAST) begin
                  col_d = '0;
                  row_d = row_q + ONE;
               end else begin
                  col_d = col_q + ONE;
               end
            end
         end
         FLUSH: begin
            // Register holds the final word until it is taken.
            if (accept) begin
               full_d  = 1'b0;
               done    = 1'b1;
               state_d = IDLE;
               row_d   = '0;
               col_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign go_rdy   = (state_q == IDLE);
   assign out_rsel = row_q;
   assign out_csel = col_q;
   assign send_val = full_q;
   assign send_msg = msg_q;

`ifdef SYSTOLIC_DRAIN_LAST_EN
   // In FLUSH the register can only hold the (size-1,size-1) word.
   assign send_last = (state_q == FLUSH) && full_q;
`endif

endmodule

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 Parameter size, default 16: array dimension; power of two, >= 2.
REQ-002 Parameter nbits, default 16: result word width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 go_val  input  1  drain request valid.
REQ-006 go_rdy  output  1  drain request ready; high only in IDLE.
REQ-007 out_rsel  output  $clog2(size)  row select driven to the array.
REQ-008 out_csel  output  $clog2(size)  column select driven to the array.
REQ-009 b_s_out  input  nbits  array result at (out_rsel,out_csel), combinational from the selects.
REQ-010 send_val  output  1  result stream valid.
REQ-011 send_rdy  input  1  result stream ready.
REQ-012 send_msg  output  nbits  result word.
REQ-013 done  output  1  one-cycle pulse when the final word is accepted downstream.

Function
REQ-014 States: IDLE, DRAIN, FLUSH.
REQ-015 IDLE -> DRAIN on go_val && go_rdy; index (r,c) set to (0,0).
REQ-016 Traversal is row-major: c increments fastest, wraps size-1 -> 0 and increments r.
REQ-017 One-entry output register; it loads b_s_out at the current index and the index advances in a cycle where the state is DRAIN and the register is empty or being consumed (send_val && send_rdy).
REQ-018 Latency: handshake at cycle T -> send_val high at T+2 with word (0,0); sustained throughput of one word per cycle while send_rdy is held high.
REQ-019 While send_val && !send_rdy, send_msg and the index are held stable; no word is skipped or duplicated.
REQ-020 Loading index (size-1,size-1) moves DRAIN -> FLUSH; the index holds at (size-1,size-1).
REQ-021 FLUSH -> IDLE when the last word is accepted; done pulses in that same cycle; go_rdy rises the next cycle.
REQ-022 go_val outside IDLE is ignored; exactly size*size words are emitted per request.
REQ-023 out_rsel/out_csel equal the registered index in every state; they are (0,0) in IDLE.

Reset
REQ-024 Reset state: IDLE, index (0,0), output register empty; send_val=0, done=0, send_msg=0, go_rdy=1.
REQ-025 Assertion of rst mid-drain aborts immediately; the pending word is discarded and no done pulse is issued.

Configuration
REQ-026 With SYSTOLIC_DRAIN_LAST_EN defined, an extra output send_last (1 bit) is present; it is high with the word (size-1,size-1) and reset to 0.
REQ-027 Without SYSTOLIC_DRAIN_LAST_EN, the port is absent and all other behaviour is identical.

Structure
REQ-028 The shared package systolic_pkg holds the drain state enum (IDLE/DRAIN/FLUSH).
REQ-029 The block is a single module with no sub-modules; the index and output register are inline.

Verification
REQ-030 size=4; array model returns 16*r+c; go pulse with send_rdy=1 -> 16 words 0x00,0x01..0x03,0x10..0x33 on consecutive cycles from T+2; done on the word 0x33.
REQ-031 send_rdy toggling 1,0,0,1 repeatedly -> same 16-word sequence with no gaps or duplicates; send_msg is stable while stalled.
REQ-032 go_val held high throughout -> second drain starts only after done; go_rdy=0 for the whole drain.
REQ-033 rst asserted after the 5th word -> send_val=0 and go_rdy=1 immediately; a new go produces word 0x00 first.
REQ-034 send_rdy=0 while the last word is pending -> state stays FLUSH; done appears only on acceptance; with SYSTOLIC_DRAIN_LAST_EN, send_last=1 only with 0x33.
